// File: rtl/tdl_sensor_pkg.sv
// Shared TDL sensor definitions: FSM encoding, delay-setting layout and
// sensor range constants common to the sample counter and the calibrator.
package tdl_sensor_pkg;

  localparam int CW = 5;  // coarse delay width
  localparam int FW = 2;  // fine delay width

  localparam logic [CW-1:0] COARSE_RST = 5'd15;
  localparam logic [FW-1:0] FINE_RST   = 2'd0;

  localparam int TDLLOW  = 0;
  localparam int TDLHIGH = 31;
  localparam int LUTLOW  = 0;
  localparam int LUTHIGH = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_ACCUM,
    S_PRESENT,
    S_WAIT_ADJ,
    S_TRACE
  } state_t;

  typedef struct packed {
    logic [CW-1:0] coarse;
    logic [FW-1:0] fine;
  } dly_t;

endpackage

// File: rtl/tdl_popcount.sv
// Registered ones-count of the sampled TDL taps, one cycle of latency.
module tdl_popcount #(
  parameter int TAPS  = 128,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAPS-1:0]  taps,
  output logic [OUT_W-1:0] pc
);

  logic [OUT_W-1:0] sum;

  // Adder chain over all taps; synthesis folds it into a tree.
  always_comb begin
    sum = '0;
    for (int i = 0; i < TAPS; i++) sum = sum + OUT_W'(taps[i]);
  end

  // Register the count so the FSM sees a stable value each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else     pc <= sum;
  end

endmodule

// File: rtl/tdl_sample_counter.sv
// Applies calibrator delay settings to the TDL sensor, settles, averages the
// tap popcount over a window and hands it to the calibrator; once inside the
// target band it streams raw per-cycle popcounts as trace data.
module tdl_sample_counter
  import tdl_sensor_pkg::*;
#(
  parameter int TAPS        = 128,
  parameter int COUNT_W     = 8,
  parameter int SETTLE      = 4,
  parameter int AVG_LOG2    = 2,
  parameter int AIM         = 64,
  parameter int TOL         = 4,
  parameter int MAX_ITER    = 40,
  parameter int ADJ_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TAPS-1:0]    tdl_taps,
  input  logic [CW-1:0]      coarse_in,
  input  logic [FW-1:0]      fine_in,
  input  logic               adj_done,
  input  logic               adj_err,
  output logic [CW-1:0]      coarse_out,
  output logic [FW-1:0]      fine_out,
  output logic [COUNT_W-1:0] count,
  output logic               en,
  output logic               busy,
  output logic               cal_ok,
  output logic               cal_fail,
  output logic [COUNT_W-1:0] trace_data,
  output logic               trace_valid
);

  localparam int ACC_W = COUNT_W + AVG_LOG2;
  localparam int AVG_N = 1 << AVG_LOG2;
  localparam int SET_W = $clog2(SETTLE + 2);
  localparam int ACN_W = AVG_LOG2 + 1;
  localparam int IT_W  = $clog2(MAX_ITER + 1);
  localparam int TO_W  = $clog2(ADJ_TIMEOUT + 1);

  state_t             state, nxt;
  dly_t               dly;
  logic [COUNT_W-1:0] pc;
  logic [SET_W-1:0]   settle_cnt;
  logic [ACC_W-1:0]   acc, acc_sum;
  logic [ACN_W-1:0]   acc_cnt;
  logic [IT_W-1:0]    iter;
  logic [TO_W-1:0]    tmo;
  logic               acc_last, iter_max, tmo_hit, in_band;
  logic               restart, fail_now;
  int                 diff;

  tdl_popcount #(.TAPS(TAPS), .OUT_W(COUNT_W)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .taps (tdl_taps),
    .pc   (pc)
  );

  assign coarse_out = dly.coarse;
  assign fine_out   = dly.fine;
  assign acc_sum    = acc + ACC_W'(pc);
  assign acc_last   = (acc_cnt == ACN_W'(AVG_N - 1));
  assign iter_max   = (iter == IT_W'(MAX_ITER));
  assign tmo_hit    = (tmo == TO_W'(ADJ_TIMEOUT - 1));

  // Band test on the presented average (count is loaded entering PRESENT).
  always_comb begin
    diff    = int'(count) - AIM;
    in_band = (diff <= TOL) && (diff >= -TOL);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic plus the restart / failure events the datapath follows.
  always_comb begin
    nxt      = state;
    restart  = 1'b0;
    fail_now = 1'b0;
    case (state)
      S_IDLE:     if (start) begin nxt = S_APPLY; restart = 1'b1; end
      S_APPLY:    nxt = S_SETTLE;
      S_SETTLE:   if (settle_cnt == SET_W'(SETTLE)) nxt = S_ACCUM;
      S_ACCUM:    if (acc_last) nxt = S_PRESENT;
      S_PRESENT:  nxt = in_band ? S_TRACE : S_WAIT_ADJ;
      S_WAIT_ADJ: begin
        // err beats done; done at the iteration limit is also a failure
        if (adj_err || tmo_hit || (adj_done && iter_max)) begin
          nxt      = S_IDLE;
          fail_now = 1'b1;
        end else if (adj_done) begin
          nxt = S_APPLY;
        end
      end
      S_TRACE:    if (start) begin nxt = S_APPLY; restart = 1'b1; end
      default:    nxt = S_IDLE;
    endcase
  end

  // Sensor delay register: only APPLY may change what drives the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 dly <= '{coarse: COARSE_RST, fine: FINE_RST};
    else if (state == S_APPLY) dly <= '{coarse: coarse_in, fine: fine_in};
  end

  // Settle counter (SETTLE+1 cycles also hides the popcount register) and
  // the averaging accumulator, which is cleared whenever not accumulating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      acc        <= '0;
      acc_cnt    <= '0;
    end else begin
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
      if (state == S_ACCUM) begin
        acc     <= acc_sum;
        acc_cnt <= acc_cnt + 1'b1;
      end else begin
        acc     <= '0;
        acc_cnt <= '0;
      end
    end
  end

  // Average and strobe are registered together so en marks the PRESENT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      en    <= 1'b0;
    end else begin
      en <= (state == S_ACCUM) && acc_last;
      if ((state == S_ACCUM) && acc_last) count <= COUNT_W'(acc_sum >> AVG_LOG2);
    end
  end

  // Iteration count per calibration run and response timeout in WAIT_ADJ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter <= '0;
      tmo  <= '0;
    end else begin
      if (restart)                                iter <= '0;
      else if ((state == S_PRESENT) && !in_band)  iter <= iter + 1'b1;
      tmo <= (state == S_WAIT_ADJ) ? tmo + 1'b1 : '0;
    end
  end

  // Status flags; ok/fail stay set until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      cal_ok   <= 1'b0;
      cal_fail <= 1'b0;
    end else if (restart) begin
      busy     <= 1'b1;
      cal_ok   <= 1'b0;
      cal_fail <= 1'b0;
    end else if ((state == S_PRESENT) && in_band) begin
      busy   <= 1'b0;
      cal_ok <= 1'b1;
    end else if (fail_now) begin
      busy     <= 1'b0;
      cal_fail <= 1'b1;
    end
  end

  // Trace stream: valid for every TRACE cycle, dropped as soon as we leave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_valid <= 1'b0;
      trace_data  <= '0;
    end else begin
      trace_valid <= (nxt == S_TRACE);
      if (nxt == S_TRACE) trace_data <= pc;
    end
  end

endmodule

// File: tb/tb_tdl_sample_counter.sv
// Scoreboard bench: stimulus plays the calibrator and pushes the expected
// averaged count per iteration; a monitor pops/compares on every en strobe
// and checks trace data while trace_valid is high.
module tb_tdl_sample_counter;

  localparam int TAPS     = 128;
  localparam int COUNT_W  = 8;
  localparam int AIM      = 64;
  localparam int TOL      = 4;
  localparam int MAX_ITER = 40;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [TAPS-1:0]    tdl_taps = '0;
  logic [4:0]         coarse_in = '0;
  logic [1:0]         fine_in = '0;
  logic               adj_done = 1'b0;
  logic               adj_err = 1'b0;
  logic [4:0]         coarse_out;
  logic [1:0]         fine_out;
  logic [COUNT_W-1:0] count;
  logic               en, busy, cal_ok, cal_fail, trace_valid;
  logic [COUNT_W-1:0] trace_data;

  logic [TAPS-1:0] ta = '0, tb_ = '0;
  bit              alt = 1'b0, ph = 1'b0;

  int checks = 0, errors = 0;
  int exp_q[$];
  int trace_exp = -1, trace_exp2 = -1;
  int s, o, l;

  tdl_sample_counter dut (
    .clk(clk), .rst(rst), .start(start), .tdl_taps(tdl_taps),
    .coarse_in(coarse_in), .fine_in(fine_in), .adj_done(adj_done), .adj_err(adj_err),
    .coarse_out(coarse_out), .fine_out(fine_out), .count(count), .en(en),
    .busy(busy), .cal_ok(cal_ok), .cal_fail(cal_fail),
    .trace_data(trace_data), .trace_valid(trace_valid)
  );

  always #5 clk = ~clk;

  // Sensor model: constant pattern, or alternating between two patterns.
  always @(negedge clk) begin
    tdl_taps = (alt && ph) ? tb_ : ta;
    ph = ~ph;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [TAPS-1:0] mk_taps(input int k);
    logic [TAPS-1:0] t;
    int n, j;
    t = '0; n = 0;
    while (n < k) begin
      j = $urandom_range(TAPS-1);
      if (!t[j]) begin t[j] = 1'b1; n++; end
    end
    return t;
  endfunction

  // Reference: mean of the 4 window samples, truncated.
  function automatic int model_avg(input int a, input int b, input bit al);
    return al ? (2*a + 2*b) / 4 : (4*a) / 4;
  endfunction

  function automatic bit model_ok(input int avg);
    return (avg >= AIM - TOL) && (avg <= AIM + TOL);
  endfunction

  // Monitor: scoreboard pop on en, trace value check on trace_valid.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_en: got count %0d, expected no strobe", count);
        end else begin
          chk("count", count, exp_q.pop_front());
        end
      end
      if (trace_valid) begin
        checks++;
        if (!(int'(trace_data) == trace_exp || int'(trace_data) == trace_exp2)) begin
          errors++;
          $display("FAIL trace_data: got %0d, expected %0d or %0d", trace_data, trace_exp, trace_exp2);
        end
      end
    end
  end

  task automatic pick(input int mode, input int it, output int a, output int b, output bit al);
    b = 0; al = 1'b0;
    case (mode)
      0: begin
        if ($urandom_range(3) == 0) a = $urandom_range(AIM + TOL + 3, AIM - TOL - 3);
        else                        a = $urandom_range(TAPS);
        al = ($urandom_range(2) == 0);
        if (al) b = $urandom_range(TAPS);
      end
      1: a = 100 - 10*it;
      3: a = 64;
      4: begin a = 60; b = 70; al = 1'b1; end
      5: a = (it == 0) ? 59 : 64;
      default: a = 0;
    endcase
  endtask

  task automatic await_en(output bit got, output int n);
    got = 1'b0; n = 0;
    while (!got && n < 60) begin
      tick(); n++;
      if (en) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL en_timeout: no en within %0d cycles", n);
    end
  endtask

  // One calibration run; mode selects the tap plan and calibrator behaviour.
  task automatic cal_run(input int mode, output int strobes, output int outcome, output int lat);
    int a, b, it, cr, fr, avg, n, w;
    bit al, got;
    strobes = 0; outcome = 0; lat = 0; it = 0;
    cr = (mode == 1) ? 20 : $urandom_range(31);
    fr = $urandom_range(3);
    coarse_in = cr[4:0]; fine_in = fr[1:0];
    pick(mode, 0, a, b, al);
    trace_exp = -1; trace_exp2 = -1;
    ta = mk_taps(a); tb_ = mk_taps(b); alt = al;
    exp_q.push_back(model_avg(a, b, al));
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_on_start", busy, 1);
    chk("cal_ok_cleared", cal_ok, 0);
    chk("cal_fail_cleared", cal_fail, 0);
    chk("trace_drop", trace_valid, 0);
    forever begin
      await_en(got, n);
      if (!got) return;
      if (strobes == 0) lat = n + 1;
      strobes++; it++;
      chk("coarse_out", coarse_out, cr);
      chk("fine_out", fine_out, fr);
      avg = model_avg(a, b, al);
      if (model_ok(avg)) begin
        trace_exp = a; trace_exp2 = al ? b : a;
        tick();
        chk("cal_ok", cal_ok, 1);
        chk("busy_done", busy, 0);
        chk("trace_valid", trace_valid, 1);
        outcome = 1;
        return;
      end
      tick();
      if (mode == 7) begin
        repeat (248) tick();
        chk("no_early_timeout", cal_fail, 0);
        w = 0;
        while (!cal_fail && w < 20) begin tick(); w++; end
        chk("timeout_fail", cal_fail, 1);
        chk("timeout_busy", busy, 0);
        outcome = 2;
        return;
      end
      w = $urandom_range(3);
      repeat (w) tick();
      if (mode == 2 && it == 5) begin
        start = 1'b1; tick(); start = 1'b0;
        chk("start_ignored_busy", busy, 1);
        chk("start_ignored_fail", cal_fail, 0);
      end
      if (mode == 6 || (mode == 0 && $urandom_range(15) == 0)) begin
        adj_err = 1'b1; adj_done = (mode == 6);
        tick();
        adj_err = 1'b0; adj_done = 1'b0;
        chk("err_fail", cal_fail, 1);
        chk("err_busy", busy, 0);
        outcome = 2;
        return;
      end
      cr = (mode == 1) ? cr - 1 : $urandom_range(31);
      fr = $urandom_range(3);
      coarse_in = cr[4:0]; fine_in = fr[1:0];
      pick(mode, it, a, b, al);
      ta = mk_taps(a); tb_ = mk_taps(b); alt = al;
      if (it < MAX_ITER) exp_q.push_back(model_avg(a, b, al));
      adj_done = 1'b1; tick(); adj_done = 1'b0;
      if (it >= MAX_ITER) begin
        chk("iter_fail", cal_fail, 1);
        chk("iter_busy", busy, 0);
        outcome = 2;
        return;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_coarse"}, coarse_out, 15);
    chk({tag, "_fine"}, fine_out, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ok"}, cal_ok, 0);
    chk({tag, "_fail"}, cal_fail, 0);
    chk({tag, "_tvalid"}, trace_valid, 0);
    chk({tag, "_tdata"}, trace_data, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();

    // Reset in the middle of ACCUM
    coarse_in = 5'd7; fine_in = 2'd2; ta = mk_taps(30); alt = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    chk("pre_rst_coarse", coarse_out, 7);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1; #1;
    chk_reset_vals("mid_rst");
    tick();
    rst = 1'b0;
    repeat (15) tick();
    chk("post_rst_idle_busy", busy, 0);

    // 64 ones: single strobe, latency 11, then trace
    cal_run(3, s, o, l);
    chk("a_latency", l, 11);
    chk("a_strobes", s, 1);
    chk("a_outcome", o, 1);
    repeat (8) begin tick(); chk("a_trace_hold", trace_valid, 1); end

    // 100,90,80,70,60 descending with coarse tracking
    cal_run(1, s, o, l);
    chk("b_strobes", s, 5);
    chk("b_outcome", o, 1);
    repeat (4) tick();

    // alternating 60/70 -> 65
    cal_run(4, s, o, l);
    chk("c_strobes", s, 1);
    chk("c_outcome", o, 1);
    repeat (6) tick();
    // 59 out of band, then 64
    cal_run(5, s, o, l);
    chk("c2_strobes", s, 2);
    chk("c2_outcome", o, 1);
    repeat (3) tick();

    // err and done together
    cal_run(6, s, o, l);
    chk("d_strobes", s, 1);
    chk("d_outcome", o, 2);
    repeat (30) tick();

    // no calibrator response
    cal_run(7, s, o, l);
    chk("e_strobes", s, 1);
    chk("e_outcome", o, 2);
    repeat (5) tick();

    // iteration limit with a stray start in WAIT_ADJ
    cal_run(2, s, o, l);
    chk("f_strobes", s, MAX_ITER);
    chk("f_outcome", o, 2);
    repeat (20) tick();

    // randomized runs
    for (int i = 0; i < 10; i++) begin
      cal_run(0, s, o, l);
      chk("rand_outcome", (o != 0) ? 1 : 0, 1);
      repeat ((o == 1) ? 5 : 3) tick();
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdl_sample_counter.md
Name: tdl_sample_counter

Overview:
- Sensor-side counterpart to the TDL delay calibrator.
- Applies the calibrator's coarse/fine delay settings to the on-chip TDL sensor, waits for the line to settle, and popcounts the sampled taps over an averaging window.
- Presents the averaged ones-count with a one-cycle `en` pulse, then waits for the calibrator's `done`/`err`.
- After converging into the target band, streams per-cycle popcounts as trace data for side-channel capture.

Parameters:
- TAPS, 128: TDL tap width sampled per clock; max 255.
- COUNT_W, 8: width of `count` and `trace_data`.
- SETTLE, 4: idle cycles after applying a new delay, before sampling.
- AVG_LOG2, 2: averaging window of 2^AVG_LOG2 samples.
- AIM, 64: target ones-count.
- TOL, 4: convergence band half-width.
- MAX_ITER, 40: calibration iteration limit.
- ADJ_TIMEOUT, 255: cycles allowed waiting for calibrator response.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin calibration (pulse; ignored while busy)
- tdl_taps  in  TAPS  sensor tap outputs, already captured in clk domain
- coarse_in  in  5  calibrator coarse setting
- fine_in  in  2  calibrator fine setting
- adj_done  in  1  calibrator finished one adjust step
- adj_err  in  1  calibrator hit range limit
- coarse_out  out  5  registered coarse setting driving sensor delay
- fine_out  out  2  registered fine setting driving sensor delay
- count  out  COUNT_W  averaged ones-count to calibrator
- en  out  1  one-cycle strobe, `count` valid
- busy  out  1  calibration in progress
- cal_ok  out  1  converged (sticky until next start)
- cal_fail  out  1  err/timeout/iteration limit (sticky until next start)
- trace_data  out  COUNT_W  per-cycle popcount in TRACE
- trace_valid  out  1  trace_data valid

Behaviour:
- Reset values (async on rst=1, from any state, mid-operation included):
  - coarse_out=15, fine_out=0, count=0.
  - en, busy, cal_ok, cal_fail, trace_valid all 0; trace_data=0.
  - Iteration, settle, accumulate and timeout counters 0; state IDLE.
- Popcount stage: pc <= popcount(tdl_taps), registered, 1-cycle latency. Range 0..TAPS, held in COUNT_W bits.
- Accumulator width: COUNT_W+AVG_LOG2. Average = acc >> AVG_LOG2, truncating.
- FSM states and transitions:
  - IDLE: `start` → APPLY; clears cal_ok/cal_fail and the iteration counter; busy=1.
  - APPLY: coarse_out<=coarse_in, fine_out<=fine_in; → SETTLE.
  - SETTLE: count SETTLE+1 cycles (covers popcount pipeline) → ACCUM, acc=0.
  - ACCUM: acc += pc for exactly 2^AVG_LOG2 cycles → PRESENT.
  - PRESENT: count<=average; en=1 for this one cycle only.
    - If |average−AIM| <= TOL: cal_ok=1, busy=0 → TRACE. The strobe is still issued, and the calibrator response is not awaited.
    - Otherwise: iteration counter +1 → WAIT_ADJ, timeout counter=0.
  - WAIT_ADJ:
    - adj_err=1 → cal_fail=1, busy=0 → IDLE. Err wins if it coincides with adj_done.
    - adj_done=1 → APPLY, unless the iteration counter equals MAX_ITER, in which case cal_fail → IDLE.
    - Timeout counter reaches ADJ_TIMEOUT → cal_fail → IDLE.
  - TRACE: trace_data<=pc, trace_valid=1 every cycle; coarse_out/fine_out frozen.
    - `start` → APPLY (recalibrate); trace_valid drops the same cycle.
- `start` in any state other than IDLE/TRACE is ignored.
- `count` holds its value between strobes.
- Delay outputs change only in APPLY.
- en latency: start→first en = 1 (APPLY) + SETTLE+1 + 2^AVG_LOG2 + 1 cycles = 11 with defaults.

Decomposition:
- Shared package (tdl_sensor_pkg):
  - FSM state encoding.
  - Coarse/fine widths (5/2) and delay reset values (15/0).
  - Sensor range constants TDLLOW=0, TDLHIGH=31, LUTLOW=0, LUTHIGH=3, shared with the calibrator.
- Sub-module `tdl_popcount`: registered popcount of TAPS bits, parameterized width, 1-cycle latency. The rest stays in the top FSM.

Test Plan:
- Reset mid-ACCUM: rst pulse → all outputs at reset values next edge; coarse_out=15, en=0, state IDLE.
- tdl_taps constant with 64 ones, start → single en pulse 11 cycles after start, count=64, cal_ok=1, trace_valid=1 with trace_data=64 each cycle.
- tdl_taps 100 ones, calibrator model answers adj_done with coarse_in decremented, taps reduce 10 ones per step → count sequence 100,90,80,70,60 → cal_ok after 5 strobes. coarse_out tracks each coarse_in one cycle into APPLY.
- Alternating taps 60/70 ones over window → average 65 (acc=260 >>2) → cal_ok. Then taps 59 ones: count 59, outside band → adj_done loop continues.
- adj_err and adj_done asserted together in WAIT_ADJ → cal_fail=1, busy=0, no further en. Separately, no response for 255 cycles → cal_fail.
- Calibrator always answers adj_done, taps fixed at 0 ones → exactly 40 en pulses, then cal_fail=1. A start issued during WAIT_ADJ is ignored.
